consumer_reorder_buf: RTL and testbench
=======================================

CONSUMER_REORDER_BUF -- requirements
Module: consumer_reorder_buf

Interface
REQ-001 SHALL have parameter DATA_W, default consumer_transaction_pkg::data_width (512), the response line width in bits.
REQ-002 SHALL have parameter ID_W, default consumer_transaction_pkg::id_width (4); depth is 2**ID_W (16).
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all logic samples on the rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have ports alloc_valid_i (in, 1), alloc_ready_o (out, 1) and alloc_id_o (out, ID_W): the upstream requests an id for an outgoing read.
REQ-006 SHALL have ports rsp_valid_i (in, 1), rsp_ready_o (out, 1), rsp_id_i (in, ID_W) and rsp_data_i (in, DATA_W): the out-of-order response line.
REQ-007 SHALL have ports deq_valid_o (out, 1), deq_ready_i (in, 1), deq_data_o (out, DATA_W) and deq_id_o (out, ID_W): the in-order line delivered to the accelerator.
REQ-008 SHALL have port err_o, out, 1 bit, when CONSUMER_ROB_ERR_CHECK_EN is defined.

Function
REQ-009 SHALL keep head_q and tail_q pointers, each ID_W+1 bits, with an empty condition head==tail and a full condition of equal index bits with differing MSB.
REQ-010 SHALL drive alloc_ready_o = !full and alloc_id_o = tail_q[ID_W-1:0]; on an alloc handshake it SHALL set pend[idx], clear filled[idx] and increment tail_q (mod 2**(ID_W+1)).
REQ-011 SHALL tie rsp_ready_o to 1; a response SHALL be accepted only if pend[rsp_id_i]=1, in which case it writes the data to slot rsp_id_i, sets filled and clears pend.
REQ-012 SHALL silently drop a response whose id is not pending, with no state change.
REQ-013 SHALL drive deq_valid_o = filled[head index], with deq_data_o and deq_id_o taken from the head slot (zero latency from the registered slot).
REQ-014 SHALL, on a deq handshake, clear filled[head] and increment head_q.
REQ-015 SHALL allow response-to-dequeue latency of minimum 1 cycle: data written in cycle N is visible on deq in cycle N+1, with no bypass.
REQ-016 SHALL process alloc, rsp and deq in the same cycle independently; a simultaneous alloc and deq when full SHALL NOT be possible, because alloc_ready_o=0 while full.
REQ-017 SHALL wrap pointers naturally, so id 15 is followed by id 0.
REQ-018 SHALL allow deq_data_o to be X-free but unspecified when deq_valid_o=0.

Reset
REQ-019 SHALL, on rst_ni=0 at a clock edge, clear head_q, tail_q, pend, filled and err_o, and drive the outputs alloc_ready_o=1, alloc_id_o=0, rsp_ready_o=1, deq_valid_o=0 and deq_id_o=0.
REQ-020 SHALL abandon all outstanding ids on reset asserted mid-operation; later responses carrying those ids SHALL be dropped per REQ-012.
REQ-021 SHALL leave slot data storage unreset.

Configuration
REQ-022 SHALL, with CONSUMER_ROB_ERR_CHECK_EN defined, set err_o sticky high the cycle after any rsp_valid_i with a non-pending id (orphan or duplicate), cleared only by reset.
REQ-023 SHALL, without CONSUMER_ROB_ERR_CHECK_EN defined, omit err_o and its logic; dropping behaviour is unchanged.

Structure
REQ-024 SHALL import data_width, id_width, id_t and data_t from shared package consumer_transaction_pkg, mirroring the producer package.
REQ-025 SHALL place the slot storage (2**ID_W x DATA_W, one write port, one read port) in sub-module consumer_rob_mem.

Verification
REQ-026 SHALL verify in-order delivery: alloc ids 0,1,2, respond in order with data A,B,C, deq_ready=1 -> deq yields (0,A),(1,B),(2,C).
REQ-027 SHALL verify reordering: alloc 0..3, respond in order 3,1,0,2 -> deq_valid stays 0 until id 0 arrives, then (0),(1) follow back-to-back and (2),(3) follow once id 2 lands.
REQ-028 SHALL verify full and wrap: 16 allocs -> alloc_ready_o=0; one deq -> alloc_ready_o=1 and the next alloc_id_o=0.
REQ-029 SHALL verify bad responses: a response with id 5 when not pending, or a second response for id 2 -> dropped, deq unchanged, and err_o=1 next cycle if the macro is defined.
REQ-030 SHALL verify backpressure: deq_ready=0 for 10 cycles with head filled -> deq_valid, deq_data and deq_id held stable.
REQ-031 SHALL verify reset mid-flight: 4 ids pending, rst_ni=0 for one cycle -> all reset values; a later response for id 1 is dropped.

Source files
------------

// File: rtl/consumer_transaction_pkg.sv
// Shared consumer-side transaction types, mirroring the producer package.
// Defines the response line width and the read id width used by the reorder buffer.
package consumer_transaction_pkg;

    localparam int unsigned data_width = 512;
    localparam int unsigned id_width   = 4;

    typedef logic [id_width-1:0]   id_t;
    typedef logic [data_width-1:0] data_t;

endpackage

// File: rtl/consumer_rob_mem.sv
// Reorder-buffer slot storage: 2**ID_W lines of DATA_W bits.
// One synchronous write port and one asynchronous read port; contents are not reset.
module consumer_rob_mem
    import consumer_transaction_pkg::*;
#(
    parameter int unsigned DATA_W = data_width,
    parameter int unsigned ID_W   = id_width
) (
    input  logic              clk_i,
    input  logic              we,
    input  logic [ID_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ID_W-1:0]   raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 2 ** ID_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/consumer_reorder_buf.sv
// Consumer reorder buffer: hands out read ids in order, accepts out-of-order responses,
// and delivers lines back in allocation order. CONSUMER_ROB_ERR_CHECK_EN adds a sticky err_o.
module consumer_reorder_buf
    import consumer_transaction_pkg::*;
#(
    parameter int unsigned DATA_W = data_width,
    parameter int unsigned ID_W   = id_width
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              alloc_valid_i,
    output logic              alloc_ready_o,
    output logic [ID_W-1:0]   alloc_id_o,
    input  logic              rsp_valid_i,
    output logic              rsp_ready_o,
    input  logic [ID_W-1:0]   rsp_id_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              deq_valid_o,
    input  logic              deq_ready_i,
    output logic [DATA_W-1:0] deq_data_o,
    output logic [ID_W-1:0]   deq_id_o
`ifdef CONSUMER_ROB_ERR_CHECK_EN
    ,
    output logic              err_o
`endif
);

    localparam int unsigned DEPTH = 2 ** ID_W;
    localparam int unsigned PTR_W = ID_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0] pend_q, pend_d, filled_q, filled_d;
    logic [ID_W-1:0]  head_idx, tail_idx;
    logic             full, alloc_fire, rsp_accept, deq_fire;
    logic [DATA_W-1:0] head_data;

    assign head_idx = head_q[ID_W-1:0];
    assign tail_idx = tail_q[ID_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[ID_W] != tail_q[ID_W]);

    assign alloc_ready_o = !full;
    assign alloc_id_o    = tail_idx;
    assign rsp_ready_o   = 1'b1;
    assign deq_valid_o   = filled_q[head_idx];
    assign deq_id_o      = head_idx;
    // Mask unreset storage so the line is X-free while nothing is deliverable.
    assign deq_data_o    = deq_valid_o ? head_data : '0;

    assign alloc_fire = alloc_valid_i && !full;
    assign rsp_accept = rsp_valid_i && pend_q[rsp_id_i];
    assign deq_fire   = deq_valid_o && deq_ready_i;

    // Alloc, response and dequeue touch disjoint slots, so updates compose freely.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        pend_d   = pend_q;
        filled_d = filled_q;
        if (rsp_accept) begin
            pend_d[rsp_id_i]   = 1'b0;
            filled_d[rsp_id_i] = 1'b1;
        end
        if (deq_fire) begin
            filled_d[head_idx] = 1'b0;
            head_d             = head_q + PTR_W'(1);
        end
        if (alloc_fire) begin
            pend_d[tail_idx]   = 1'b1;
            filled_d[tail_idx] = 1'b0;
            tail_d             = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            pend_q   <= '0;
            filled_q <= '0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            pend_q   <= pend_d;
            filled_q <= filled_d;
        end
    end

`ifdef CONSUMER_ROB_ERR_CHECK_EN
    logic err_q;

    // Sticky flag for any response whose id was not outstanding.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (rsp_valid_i & ~pend_q[rsp_id_i]);
        end
    end

    assign err_o = err_q;
`endif

    consumer_rob_mem #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W)
    ) u_mem (
        .clk_i  (clk_i),
        .we     (rsp_accept),
        .waddr  (rsp_id_i),
        .wdata  (rsp_data_i),
        .raddr  (head_idx),
        .rdata  (head_data)
    );

endmodule

// File: tb/tb_consumer_reorder_buf.sv
// Self-checking bench for consumer_reorder_buf: directed scenarios plus random traffic
// against an in-order queue model of outstanding ids.
module tb_consumer_reorder_buf;
    import consumer_transaction_pkg::*;

    localparam int unsigned DW    = data_width;
    localparam int unsigned IW    = id_width;
    localparam int          DEPTH = 2 ** IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic          alloc_ready;
    logic [IW-1:0] alloc_id;
    logic          rsp_valid = 1'b0;
    logic          rsp_ready;
    logic [IW-1:0] rsp_id = '0;
    data_t         rsp_data = '0;
    logic          deq_valid;
    logic          deq_ready = 1'b0;
    data_t         deq_data;
    logic [IW-1:0] deq_id;
`ifdef CONSUMER_ROB_ERR_CHECK_EN
    logic          err;
`endif

    consumer_reorder_buf dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .alloc_valid_i (alloc_valid),
        .alloc_ready_o (alloc_ready),
        .alloc_id_o    (alloc_id),
        .rsp_valid_i   (rsp_valid),
        .rsp_ready_o   (rsp_ready),
        .rsp_id_i      (rsp_id),
        .rsp_data_i    (rsp_data),
        .deq_valid_o   (deq_valid),
        .deq_ready_i   (deq_ready),
        .deq_data_o    (deq_data),
        .deq_id_o      (deq_id)
`ifdef CONSUMER_ROB_ERR_CHECK_EN
        ,
        .err_o         (err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: queue of outstanding ids in allocation order plus per-id status.
    int    mq[$];
    bit    m_pend   [DEPTH];
    bit    m_filled [DEPTH];
    data_t m_data   [DEPTH];
    int    m_next = 0;
    bit    m_err = 1'b0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic data_t rand_data();
        data_t d;
        for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic compare_model();
        bit exp_v;
        int exp_head;
        exp_v    = (mq.size() > 0) && m_filled[mq[0]];
        exp_head = (mq.size() > 0) ? mq[0] : m_next;
        chk("alloc_ready", DW'(alloc_ready), DW'(mq.size() < DEPTH));
        chk("alloc_id", DW'(alloc_id), DW'(m_next));
        chk("rsp_ready", DW'(rsp_ready), DW'(1));
        chk("deq_valid", DW'(deq_valid), DW'(exp_v));
        chk("deq_id", DW'(deq_id), DW'(exp_head));
        if (exp_v) chk("deq_data", deq_data, m_data[mq[0]]);
`ifdef CONSUMER_ROB_ERR_CHECK_EN
        chk("err", DW'(err), DW'(m_err));
`endif
    endtask

    task automatic model_step(input bit rst, input bit av, input bit rv, input int rid,
                              input data_t rd, input bit dr);
        bit a_fire, d_fire, r_ok;
        if (!rst) begin
            mq.delete();
            for (int i = 0; i < DEPTH; i++) begin
                m_pend[i]   = 1'b0;
                m_filled[i] = 1'b0;
            end
            m_next = 0;
            m_err  = 1'b0;
            return;
        end
        a_fire = av && (mq.size() < DEPTH);
        d_fire = dr && (mq.size() > 0) && m_filled[mq[0]];
        r_ok   = rv && m_pend[rid];
        if (rv && !m_pend[rid]) m_err = 1'b1;
        if (r_ok) begin
            m_data[rid]   = rd;
            m_filled[rid] = 1'b1;
            m_pend[rid]   = 1'b0;
        end
        if (d_fire) begin
            m_filled[mq[0]] = 1'b0;
            void'(mq.pop_front());
        end
        if (a_fire) begin
            mq.push_back(m_next);
            m_pend[m_next]   = 1'b1;
            m_filled[m_next] = 1'b0;
            m_next = (m_next + 1) % DEPTH;
        end
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model after the rising edge.
    task automatic cycle(input bit rst, input bit av, input bit rv, input int rid,
                         input data_t rd, input bit dr);
        rst_n       = rst;
        alloc_valid = av;
        rsp_valid   = rv;
        rsp_id      = IW'(rid);
        rsp_data    = rd;
        deq_ready   = dr;
        @(negedge clk);
        if (chk_en) compare_model();
        @(posedge clk);
        #1;
        model_step(rst, av, rv, rid, rd, dr);
        if (!rst) chk_en = 1'b1;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b0, 0, '0, 1'b0);
    endtask

    task automatic idle(input bit dr);
        cycle(1'b1, 1'b0, 1'b0, 0, '0, dr);
    endtask

    task automatic alloc_n(input int n, input bit dr);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 0, '0, dr);
    endtask

    task automatic rsp(input int id, input data_t d, input bit dr);
        cycle(1'b1, 1'b0, 1'b1, id, d, dr);
    endtask

    data_t da, db, dc, dd;

    initial begin
        do_reset();
        do_reset();
        chk("rst_alloc_ready", DW'(alloc_ready), DW'(1));
        chk("rst_alloc_id", DW'(alloc_id), DW'(0));
        chk("rst_deq_valid", DW'(deq_valid), DW'(0));
        chk("rst_deq_id", DW'(deq_id), DW'(0));

        // In-order delivery
        da = rand_data(); db = rand_data(); dc = rand_data();
        alloc_n(3, 1'b1);
        rsp(0, da, 1'b1);
        chk("inorder_id0", DW'(deq_id), DW'(0));
        chk("inorder_dA", deq_data, da);
        rsp(1, db, 1'b1);
        chk("inorder_id1", DW'(deq_id), DW'(1));
        chk("inorder_dB", deq_data, db);
        rsp(2, dc, 1'b1);
        chk("inorder_id2", DW'(deq_id), DW'(2));
        chk("inorder_dC", deq_data, dc);
        idle(1'b1);
        chk("inorder_drained", DW'(deq_valid), DW'(0));

        // Reordering 3,1,0,2
        do_reset();
        alloc_n(4, 1'b1);
        rsp(3, rand_data(), 1'b1);
        chk("reord_wait3", DW'(deq_valid), DW'(0));
        rsp(1, rand_data(), 1'b1);
        chk("reord_wait1", DW'(deq_valid), DW'(0));
        rsp(0, rand_data(), 1'b1);
        chk("reord_v0", DW'(deq_valid), DW'(1));
        chk("reord_id0", DW'(deq_id), DW'(0));
        idle(1'b1);
        chk("reord_id1", DW'(deq_id), DW'(1));
        idle(1'b1);
        chk("reord_gap", DW'(deq_valid), DW'(0));
        rsp(2, rand_data(), 1'b1);
        chk("reord_id2", DW'(deq_id), DW'(2));
        idle(1'b1);
        chk("reord_id3", DW'(deq_id), DW'(3));
        idle(1'b1);
        chk("reord_empty", DW'(deq_valid), DW'(0));

        // Full and wrap
        do_reset();
        alloc_n(16, 1'b0);
        chk("full_ready", DW'(alloc_ready), DW'(0));
        alloc_n(1, 1'b0);
        rsp(0, rand_data(), 1'b0);
        idle(1'b1);
        chk("wrap_ready", DW'(alloc_ready), DW'(1));
        chk("wrap_id", DW'(alloc_id), DW'(0));
        alloc_n(1, 1'b0);
        chk("refull_ready", DW'(alloc_ready), DW'(0));

        // Bad responses: orphan id 5, duplicate id 2
        do_reset();
        alloc_n(3, 1'b0);
        rsp(5, rand_data(), 1'b1);
        chk("orphan_deq", DW'(deq_valid), DW'(0));
`ifdef CONSUMER_ROB_ERR_CHECK_EN
        chk("orphan_err", DW'(err), DW'(1));
`endif
        do_reset();
        dd = rand_data();
        alloc_n(3, 1'b0);
        rsp(2, dd, 1'b0);
        rsp(2, rand_data(), 1'b0);
`ifdef CONSUMER_ROB_ERR_CHECK_EN
        chk("dup_err", DW'(err), DW'(1));
`endif
        rsp(0, rand_data(), 1'b0);
        rsp(1, rand_data(), 1'b0);
        idle(1'b1);
        idle(1'b1);
        chk("dup_id", DW'(deq_id), DW'(2));
        chk("dup_keeps_first", deq_data, dd);

        // Backpressure
        do_reset();
        da = rand_data();
        alloc_n(1, 1'b0);
        rsp(0, da, 1'b0);
        for (int i = 0; i < 10; i++) begin
            idle(1'b0);
            chk("bp_valid", DW'(deq_valid), DW'(1));
            chk("bp_id", DW'(deq_id), DW'(0));
            chk("bp_data", deq_data, da);
        end

        // Reset mid-flight
        do_reset();
        alloc_n(4, 1'b0);
        do_reset();
        chk("mid_alloc_ready", DW'(alloc_ready), DW'(1));
        chk("mid_alloc_id", DW'(alloc_id), DW'(0));
        chk("mid_deq_valid", DW'(deq_valid), DW'(0));
        chk("mid_deq_id", DW'(deq_id), DW'(0));
`ifdef CONSUMER_ROB_ERR_CHECK_EN
        chk("mid_err", DW'(err), DW'(0));
`endif
        rsp(1, rand_data(), 1'b1);
        chk("mid_stale_dropped", DW'(deq_valid), DW'(0));
        chk("mid_stale_alloc_id", DW'(alloc_id), DW'(0));

        // Random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int pl[$];
            int rid;
            bit rst_b, av, rv, dr;
            rst_b = ($urandom_range(0, 499) != 0);
            av    = ($urandom_range(0, 9) < 6);
            rv    = ($urandom_range(0, 9) < 6);
            dr    = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < DEPTH; i++) if (m_pend[i]) pl.push_back(i);
            if (pl.size() > 0 && $urandom_range(0, 9) < 8)
                rid = pl[$urandom_range(0, pl.size() - 1)];
            else
                rid = int'($urandom_range(0, DEPTH - 1));
            cycle(rst_b, av, rv, rid, rand_data(), dr);
        end
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
